rtc_cfg_regs: RTL and testbench
===============================

Name: rtc_cfg_regs

Overview:
Configuration register bank of the CAN controller; the responder on the register side of rtc_mc_if. It decodes the one-hot register-select vector, performs the read or write, and returns data with a one-cycle ack/error pulse. It holds the RW control registers driven to the CAN core, exposes read-only status words from the core, and keeps a write-1-to-clear interrupt flag register with mask-qualified IRQ output.

Parameters:
NUM_RW, 8, RW registers at select indices 0..NUM_RW-1; index NUM_RW-1 is IRQ_MASK.
NUM_RO, 4, RO status registers at indices NUM_RW..NUM_RW+NUM_RO-1.
IRQ_IDX, 12, select index of the W1C interrupt flag register; must equal NUM_RW+NUM_RO.

Ports:
i_sys_clk  in  1  100 MHz system clock
i_reset_n  in  1  asynchronous active-low reset
i_rs_vector  in  31  one-hot register select from rtc_mc_if; all-zero = no request
i_reg_w_bus  in  32  write data
i_r_neg_w  in  1  1 = read, 0 = write
o_reg_r_data  out  32  read data, valid while o_reg_ack=1 and held afterwards
o_reg_ack  out  1  one-cycle completion pulse
o_reg_error  out  1  one-cycle error pulse, coincident with o_reg_ack
i_status  in  32*NUM_RO  status words from the CAN core; word k is at index NUM_RW+k
i_irq_set  in  32  per-bit interrupt set pulses from the core
o_cfg_regs  out  32*NUM_RW  flattened RW register contents to the core
o_irq_flags  out  32  interrupt flag register
o_irq  out  1  |(o_irq_flags & IRQ_MASK)

Behaviour:
- Reset (async, i_reset_n=0): all RW registers, flags, o_reg_r_data, o_reg_ack, o_reg_error = 0; FSM -> IDLE.
- FSM states: IDLE, ACCESS, ACK, WAIT_REL.
- IDLE: on an edge with i_rs_vector != 0, latch the vector, i_r_neg_w and i_reg_w_bus, then go to ACCESS.
- ACCESS: classify the latched request:
  - multi-hot vector -> error;
  - index > IRQ_IDX -> error;
  - write to an RO index -> error.
- ACCESS, same edge: on success, commit the write or load read data; go to ACK. o_reg_ack (and o_reg_error if applicable) is high for exactly the ACK cycle. Latency: select sampled at edge N, ack visible from edge N+2 for one cycle.
- On error: no register changes; o_reg_r_data = 0.
- Abort: if i_rs_vector == 0 while in ACCESS, drop the request with no commit and no ack, and return to IDLE.
- ACK -> WAIT_REL. WAIT_REL -> IDLE once i_rs_vector == 0. A held select never causes a second access. A new nonzero vector after release starts a new access.
- Read sources:
  - RW index: register value.
  - RO index: i_status word sampled in ACCESS.
  - IRQ_IDX: o_irq_flags.
- Writes:
  - RW index: full 32-bit replace.
  - IRQ_IDX: flags &= ~i_reg_w_bus (W1C).
- Flags: flags |= i_irq_set every cycle. On the same cycle as a W1C, set wins per bit.
- o_irq is combinational from the flags and IRQ_MASK registers.
- o_cfg_regs changes on the edge that commits the write, one cycle before o_reg_ack.

Decomposition:
- Package rtc_cfg_pkg:
  - state enum cfg_state_t;
  - constants NUM_RW, NUM_RO, IRQ_IDX, IRQ_MASK_IDX;
  - RW register index names (CTRL=0, BIT_TIMING=1, …).
- Sub-module rtc_onehot_dec: 31-bit vector to {valid, multi_hot, index[4:0]}. It is combinational and reused by the abort check.

Test Plan:
- Write i_rs_vector=31'h1, W=0x0000_00A5, held until ack:
  - o_cfg_regs word0 = 0xA5 one cycle before the ack;
  - o_reg_ack pulses at N+2, o_reg_error=0.
- Read index 0 after the above:
  - o_reg_r_data = 0xA5 with the ack pulse;
  - no second ack while the select is held for 5 more cycles.
- Read RO index 8 with i_status word0 = 0xDEAD_BEEF:
  - data 0xDEADBEEF, error=0.
- Write to index 8:
  - ack and error pulse together;
  - a later read still returns the status value.
- Error requests: select 31'h3 (multi-hot), then 31'h4000_0000 (index 30):
  - each gives ack+error, data 0;
  - RW registers unchanged.
- Interrupt sequence:
  - i_irq_set=0x5, IRQ_MASK=0x4 -> o_irq=1;
  - W1C write 0x4 with a simultaneous i_irq_set=0x4 -> flags stay 0x5;
  - W1C 0x5 alone -> flags 0, o_irq=0.
- Abort and reset mid-operation:
  - drop the select during ACCESS -> no ack, no commit;
  - assert i_reset_n=0 mid-ACK -> all outputs 0 immediately.

Source files
------------

// File: rtl/rtc_cfg_pkg.sv
// Shared constants, register index names and FSM state type for the
// CAN controller configuration register bank.
package rtc_cfg_pkg;

  localparam int unsigned NUM_RW       = 8;
  localparam int unsigned NUM_RO       = 4;
  localparam int unsigned IRQ_IDX      = NUM_RW + NUM_RO;
  localparam int unsigned IRQ_MASK_IDX = NUM_RW - 1;

  localparam int unsigned CTRL        = 0;
  localparam int unsigned BIT_TIMING  = 1;
  localparam int unsigned FILTER_ID   = 2;
  localparam int unsigned FILTER_MASK = 3;
  localparam int unsigned TX_CFG      = 4;
  localparam int unsigned RX_CFG      = 5;
  localparam int unsigned ERR_LIMIT   = 6;
  localparam int unsigned IRQ_MASK    = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACK,
    ST_WAIT_REL
  } cfg_state_t;

endpackage

// File: rtl/rtc_onehot_dec.sv
// Register-select decoder: flags any request, flags multi-hot selects and
// returns the bit position of the selected register.
module rtc_onehot_dec (
  input  logic [30:0] i_vec,
  output logic        o_valid,
  output logic        o_multi_hot,
  output logic [4:0]  o_index
);

  always_comb begin
    o_valid     = |i_vec;
    o_multi_hot = |(i_vec & (i_vec - 31'd1));
    o_index     = '0;
    // Highest set bit wins; only meaningful for a one-hot vector anyway.
    for (int unsigned i = 0; i < 31; i++) begin
      if (i_vec[i]) o_index = 5'(i);
    end
  end

endmodule

// File: rtl/rtc_cfg_regs.sv
// CAN controller configuration register bank: one-hot select decode,
// RW control registers, RO status words and W1C interrupt flags.
module rtc_cfg_regs #(
  parameter int unsigned NUM_RW  = rtc_cfg_pkg::NUM_RW,
  parameter int unsigned NUM_RO  = rtc_cfg_pkg::NUM_RO,
  parameter int unsigned IRQ_IDX = rtc_cfg_pkg::IRQ_IDX
) (
  input  logic                   i_sys_clk,
  input  logic                   i_reset_n,
  input  logic [30:0]            i_rs_vector,
  input  logic [31:0]            i_reg_w_bus,
  input  logic                   i_r_neg_w,
  output logic [31:0]            o_reg_r_data,
  output logic                   o_reg_ack,
  output logic                   o_reg_error,
  input  logic [32*NUM_RO-1:0]   i_status,
  input  logic [31:0]            i_irq_set,
  output logic [32*NUM_RW-1:0]   o_cfg_regs,
  output logic [31:0]            o_irq_flags,
  output logic                   o_irq
);
  import rtc_cfg_pkg::*;

  localparam int unsigned MASK_IDX = NUM_RW - 1;

  cfg_state_t  r_state;
  logic [4:0]  r_idx;
  logic        r_multi;
  logic        r_rnw;
  logic [31:0] r_wdata;
  logic [31:0] r_cfg [NUM_RW];
  logic [31:0] r_flags;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_err;
  logic        r_err_pend;

  logic        w_valid;
  logic        w_multi;
  logic [4:0]  w_idx;
  logic        w_is_ro;
  logic        w_err;
  logic        w_w1c;
  logic [31:0] w_rd;

  // The live select is decoded once: IDLE latches the decoded form, ACCESS
  // and WAIT_REL use its valid bit to detect release/abort.
  rtc_onehot_dec u_dec (
    .i_vec       (i_rs_vector),
    .o_valid     (w_valid),
    .o_multi_hot (w_multi),
    .o_index     (w_idx)
  );

  always_comb begin
    w_is_ro = (32'(r_idx) >= NUM_RW) && (32'(r_idx) < NUM_RW + NUM_RO);
    w_err   = r_multi || (32'(r_idx) > IRQ_IDX) || (!r_rnw && w_is_ro);
    w_w1c   = (r_state == ST_ACCESS) && w_valid && !w_err && !r_rnw
              && (32'(r_idx) == IRQ_IDX);
    w_rd    = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (32'(r_idx) == i) w_rd = r_cfg[i];
    end
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if (32'(r_idx) == NUM_RW + k) w_rd = i_status[k*32 +: 32];
    end
    if (32'(r_idx) == IRQ_IDX) w_rd = r_flags;
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_multi    <= 1'b0;
      r_rnw      <= 1'b0;
      r_wdata    <= '0;
      r_flags    <= '0;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_err_pend <= 1'b0;
      for (int unsigned i = 0; i < NUM_RW; i++) r_cfg[i] <= '0;
    end else begin
      // Set pulses are OR-ed after the clear so a same-cycle set wins.
      r_flags <= (r_flags & ~(w_w1c ? r_wdata : '0)) | i_irq_set;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_idx   <= w_idx;
            r_multi <= w_multi;
            r_rnw   <= i_r_neg_w;
            r_wdata <= i_reg_w_bus;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!w_valid) begin
            r_state <= ST_IDLE;
          end else begin
            r_err_pend <= w_err;
            if (w_err) begin
              r_rdata <= '0;
            end else if (r_rnw) begin
              r_rdata <= w_rd;
            end else begin
              for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (32'(r_idx) == i) r_cfg[i] <= r_wdata;
              end
            end
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_ack   <= 1'b1;
          r_err   <= r_err_pend;
          r_state <= ST_WAIT_REL;
        end
        ST_WAIT_REL: begin
          if (!w_valid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_cfg_regs = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) o_cfg_regs[i*32 +: 32] = r_cfg[i];
  end

  assign o_reg_r_data = r_rdata;
  assign o_reg_ack    = r_ack;
  assign o_reg_error  = r_err;
  assign o_irq_flags  = r_flags;
  assign o_irq        = |(r_flags & r_cfg[MASK_IDX]);

endmodule

// File: tb/tb_rtc_cfg_regs.sv
// Directed bench for rtc_cfg_regs: access timing, read sources, error
// cases, W1C interrupt flags, abort and asynchronous reset.
module tb_rtc_cfg_regs;

  logic         clk;
  logic         rst_n;
  logic [30:0]  rs;
  logic [31:0]  wbus;
  logic         rnw;
  logic [31:0]  rdata;
  logic         ack;
  logic         err;
  logic [127:0] status;
  logic [31:0]  irq_set;
  logic [255:0] cfg;
  logic [31:0]  flags;
  logic         irq;

  int unsigned n_pass;
  int unsigned n_chk;

  logic         s_ack0, s_ack1, s_ack2, s_err2, s_ack3;
  logic [31:0]  s_data2;
  logic [255:0] s_cfg1;
  logic [255:0] exp_cfg;
  int unsigned  n_extra;

  rtc_cfg_regs #(.NUM_RW(8), .NUM_RO(4), .IRQ_IDX(12)) dut (
    .i_sys_clk    (clk),
    .i_reset_n    (rst_n),
    .i_rs_vector  (rs),
    .i_reg_w_bus  (wbus),
    .i_r_neg_w    (rnw),
    .o_reg_r_data (rdata),
    .o_reg_ack    (ack),
    .o_reg_error  (err),
    .i_status     (status),
    .i_irq_set    (irq_set),
    .o_cfg_regs   (cfg),
    .o_irq_flags  (flags),
    .o_irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; samples the three negedges after the select edge.
  task automatic access(input logic [30:0] vec, input logic r, input logic [31:0] wd,
                        input logic [31:0] irq_at_commit);
    rs = vec; rnw = r; wbus = wd;
    @(negedge clk); s_ack0 = ack; irq_set = irq_at_commit;
    @(negedge clk); s_ack1 = ack; s_cfg1 = cfg; irq_set = '0;
    @(negedge clk); s_ack2 = ack; s_err2 = err; s_data2 = rdata;
  endtask

  task automatic release_sel();
    rs = '0;
    @(negedge clk); s_ack3 = ack;
  endtask

  initial begin
    n_pass = 0; n_chk = 0;
    rst_n = 1'b0; rs = '0; wbus = '0; rnw = 1'b0; irq_set = '0;
    status = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    exp_cfg = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_flags", flags, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write CTRL = 0xA5
    access(31'h1, 1'b0, 32'h0000_00A5, '0);
    exp_cfg[31:0] = 32'hA5;
    chk("wr0_ack_n1", s_ack0, 0);
    chk("wr0_ack_n2", s_ack1, 0);
    chk("wr0_cfg_pre_ack", s_cfg1, exp_cfg);
    chk("wr0_ack", s_ack2, 1);
    chk("wr0_err", s_err2, 0);
    release_sel();
    chk("wr0_ack_one_cycle", s_ack3, 0);

    // Read CTRL, select held 5 extra cycles
    access(31'h1, 1'b1, '0, '0);
    chk("rd0_ack", s_ack2, 1);
    chk("rd0_err", s_err2, 0);
    chk("rd0_data", s_data2, 32'hA5);
    n_extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack) n_extra++;
    end
    chk("rd0_no_second_ack", n_extra, 0);
    chk("rd0_data_held", rdata, 32'hA5);
    release_sel();

    // Read RO status word 0
    access(31'h100, 1'b1, '0, '0);
    chk("ro8_ack", s_ack2, 1);
    chk("ro8_err", s_err2, 0);
    chk("ro8_data", s_data2, 32'hDEAD_BEEF);
    release_sel();
    access(31'h200, 1'b1, '0, '0);
    chk("ro9_data", s_data2, 32'h2222_2222);
    release_sel();

    // Write to RO index is an error
    access(31'h100, 1'b0, 32'h1234_5678, '0);
    chk("wr_ro_ack", s_ack2, 1);
    chk("wr_ro_err", s_err2, 1);
    chk("wr_ro_data", s_data2, 0);
    release_sel();
    access(31'h100, 1'b1, '0, '0);
    chk("ro8_after_wr", s_data2, 32'hDEAD_BEEF);
    release_sel();

    // Multi-hot and out-of-range selects
    access(31'h3, 1'b0, 32'hFFFF_FFFF, '0);
    chk("multi_ack", s_ack2, 1);
    chk("multi_err", s_err2, 1);
    chk("multi_data", s_data2, 0);
    release_sel();
    access(31'h4000_0000, 1'b0, 32'hFFFF_FFFF, '0);
    chk("idx30_ack", s_ack2, 1);
    chk("idx30_err", s_err2, 1);
    chk("idx30_data", s_data2, 0);
    release_sel();
    chk("err_cfg_unchanged", cfg, exp_cfg);

    // Interrupts
    irq_set = 32'h5;
    @(negedge clk);
    irq_set = '0;
    chk("irq_flags_set", flags, 32'h5);
    chk("irq_masked_off", irq, 0);
    access(31'h80, 1'b0, 32'h4, '0);
    release_sel();
    exp_cfg[255:224] = 32'h4;
    chk("irq_mask_cfg", cfg, exp_cfg);
    chk("irq_on", irq, 1);
    access(31'h1000, 1'b0, 32'h4, 32'h4);
    chk("w1c_set_ack", s_ack2, 1);
    chk("w1c_set_err", s_err2, 0);
    release_sel();
    chk("w1c_set_wins", flags, 32'h5);
    chk("w1c_set_irq", irq, 1);
    access(31'h1000, 1'b1, '0, '0);
    chk("rd_flags", s_data2, 32'h5);
    release_sel();
    access(31'h1000, 1'b0, 32'h5, '0);
    release_sel();
    chk("w1c_clear", flags, 0);
    chk("w1c_irq_off", irq, 0);

    // Abort: select dropped during ACCESS
    rs = 31'h2; rnw = 1'b0; wbus = 32'h77;
    @(negedge clk);
    rs = '0;
    n_extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack) n_extra++;
    end
    chk("abort_no_ack", n_extra, 0);
    chk("abort_no_commit", cfg, exp_cfg);

    // Reset during the ack cycle
    access(31'h4, 1'b0, 32'h99, '0);
    exp_cfg[95:64] = 32'h99;
    chk("pre_rst_ack", s_ack2, 1);
    chk("pre_rst_cfg", cfg, exp_cfg);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_cfg", cfg, 0);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_irq", irq, 0);
    rs = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
